// File: rtl/lfsr_stim_gen.sv
// lfsr_stim_gen: seedable Fibonacci LFSR stimulus source.
// Each run delivers NUM_PATTERNS words over a valid/ready handshake.
// The LFSR keeps running across runs unless it is reseeded, and a zero
// seed is always replaced by 1 so the register can never lock up.
module lfsr_stim_gen #(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   TAPS         = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0]   SEED         = WIDTH'(8'hA5),
    parameter int                 NUM_PATTERNS = 10,
    parameter int                 CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              seed_we,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_word,
    output logic              out_bit,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Count value that, once transferred, completes the run.
    localparam logic [CNT_W-1:0] LAST_CNT =
        (NUM_PATTERNS > 0) ? CNT_W'(NUM_PATTERNS - 1) : '0;
    localparam logic [WIDTH-1:0] ONE_WORD = WIDTH'(1);

    logic [1:0]        state_reg, state_next;
    logic [WIDTH-1:0]  lfsr_reg,  lfsr_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic              valid_reg, valid_next;
    logic              busy_reg,  busy_next;
    logic              done_reg,  done_next;

    logic [WIDTH-1:0]  tap_terms;
    logic              feedback;
    logic [WIDTH-1:0]  lfsr_stepped;
    logic [WIDTH-1:0]  seed_fixed;
    logic              xfer;

    // Mask each LFSR bit by its tap so the feedback is one XOR reduction.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_tap
            assign tap_terms[gi] = lfsr_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign feedback     = ^tap_terms;
    assign lfsr_stepped = {lfsr_reg[WIDTH-2:0], feedback};

    // An all-zero seed would freeze the LFSR, so it is replaced by 1.
    assign seed_fixed   = (seed_in == '0) ? ONE_WORD : seed_in;

    // A pattern moves only while presented and accepted in the same cycle.
    assign xfer         = valid_reg & out_ready;

    // Next-state, LFSR, counter and status-flag decisions.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        cnt_next   = cnt_reg;
        done_next  = done_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // Seeding is only allowed while no run is in progress; a
                // simultaneous start sees the new seed as its first word.
                if (seed_we) begin
                    lfsr_next = seed_fixed;
                end
                if (start) begin
                    cnt_next = '0;
                    if (NUM_PATTERNS == 0) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        done_next  = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                // start and seed_we are deliberately ignored here.
                if (xfer) begin
                    lfsr_next = lfsr_stepped;
                    cnt_next  = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                done_next  = 1'b0;
            end
        endcase

        valid_next = (state_next == ST_RUN);
        busy_next  = (state_next == ST_RUN);
    end

    // State registers; reset drops any in-flight pattern immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lfsr_reg  <= SEED;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_word  = lfsr_reg;
    assign out_bit   = lfsr_reg[0];
    assign pat_cnt   = cnt_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
